fixed_point_divider: RTL and testbench

//   Signed fixed-point divider for the FFT datapath (Q(W-F).F two's complement, F = FRAC_BITS).

---
 rtl/fixed_point_divider.sv | 146 ++++++++++++++
 tb/tb_fixed_point_divider.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_divider.sv
// Signed Q(W-F).F fixed-point divider: restoring algorithm, one quotient bit per clock,
// start/done handshake, saturating result with divide-by-zero and overflow flags.
module fixed_point_divider #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = DATA_WIDTH / 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] Quotient_o,
    output logic                  div_by_zero,
    output logic                  overflow_o
);
    localparam int W  = DATA_WIDTH;
    localparam int F  = FRAC_BITS;
    localparam int NW = W + F;
    localparam int CW = $clog2(NW + 1);

    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t        state_reg, state_next;
    logic [NW-1:0] num_reg;
    logic [NW-1:0] quo_reg;
    logic [W-1:0]  den_reg;
    logic [W-1:0]  rem_reg;
    logic [CW-1:0] cnt_reg;
    logic          sign_reg;
    logic          dz_reg;
    logic          neg1_reg;
    logic [W-1:0]  quotient_reg;
    logic          done_reg;
    logic          dbz_reg;
    logic          ovf_reg;

    logic [W-1:0]  abs1, abs2;
    logic [W:0]    rem_shift;
    logic          step_ge;
    logic [W-1:0]  rem_next;
    logic          ovf_pos, ovf_neg;
    logic [W-1:0]  result_q;
    logic          result_ovf;
    logic          last_step;

    // Unsigned magnitudes: the most negative value maps to 2^(W-1) without wrapping.
    always_comb begin
        abs1 = in1[W-1] ? (~in1 + W'(1)) : in1;
        abs2 = in2[W-1] ? (~in2 + W'(1)) : in2;
    end

    // One restoring step; the partial remainder stays below the divisor so W bits suffice.
    always_comb begin
        rem_shift = {rem_reg, num_reg[NW-1]};
        step_ge   = rem_shift >= {1'b0, den_reg};
        rem_next  = step_ge ? W'(rem_shift - {1'b0, den_reg}) : rem_shift[W-1:0];
        last_step = (cnt_reg == CW'(NW - 1));
    end

    always_comb begin
        ovf_pos    = |quo_reg[NW-1:W-1];
        ovf_neg    = (|quo_reg[NW-1:W]) || (quo_reg[W-1] && (|quo_reg[W-2:0]));
        result_q   = '0;
        result_ovf = 1'b0;
        if (dz_reg) begin
            result_q = neg1_reg ? MIN_NEG : MAX_POS;
        end else if (!sign_reg && ovf_pos) begin
            result_q   = MAX_POS;
            result_ovf = 1'b1;
        end else if (sign_reg && ovf_neg) begin
            result_q   = MIN_NEG;
            result_ovf = 1'b1;
        end else begin
            result_q = sign_reg ? (~quo_reg[W-1:0] + W'(1)) : quo_reg[W-1:0];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = (in2 == '0) ? FIN : CALC;
            CALC: if (last_step) state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            num_reg      <= '0;
            quo_reg      <= '0;
            den_reg      <= '0;
            rem_reg      <= '0;
            cnt_reg      <= '0;
            sign_reg     <= 1'b0;
            dz_reg       <= 1'b0;
            neg1_reg     <= 1'b0;
            quotient_reg <= '0;
            done_reg     <= 1'b0;
            dbz_reg      <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        num_reg  <= {abs1, {F{1'b0}}};
                        den_reg  <= abs2;
                        quo_reg  <= '0;
                        rem_reg  <= '0;
                        cnt_reg  <= '0;
                        sign_reg <= in1[W-1] ^ in2[W-1];
                        neg1_reg <= in1[W-1];
                        dz_reg   <= (in2 == '0);
                    end
                end
                CALC: begin
                    num_reg <= num_reg << 1;
                    rem_reg <= rem_next;
                    quo_reg <= {quo_reg[NW-2:0], step_ge};
                    cnt_reg <= cnt_reg + CW'(1);
                end
                FIN: begin
                    quotient_reg <= result_q;
                    dbz_reg      <= dz_reg;
                    ovf_reg      <= result_ovf;
                    done_reg     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign Quotient_o  = quotient_reg;
    assign div_by_zero = dbz_reg;
    assign overflow_o  = ovf_reg;
endmodule

// File: tb/tb_fixed_point_divider.sv
// Randomised and directed bench for fixed_point_divider (W=32, F=16) against an
// arithmetic reference model of signed fixed-point division with saturation.
module tb_fixed_point_divider;
    localparam int LAT_NORM = 49;
    localparam int LIMIT    = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] in1, in2;
    logic        busy, done, div_by_zero, overflow_o;
    logic [31:0] Quotient_o;

    int errors = 0;
    int checks = 0;

    fixed_point_divider #(.DATA_WIDTH(32), .FRAC_BITS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
        .busy(busy), .done(done), .Quotient_o(Quotient_o),
        .div_by_zero(div_by_zero), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic dz, output logic ov);
        longint sa, sb;
        longint unsigned ma, mb, qm;
        logic neg;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        if (b == 32'd0) begin
            dz = 1'b1;
            q  = (sa >= 0) ? 32'h7FFFFFFF : 32'h80000000;
        end else begin
            ma  = (sa < 0) ? -sa : sa;
            mb  = (sb < 0) ? -sb : sb;
            neg = (sa < 0) != (sb < 0);
            qm  = (ma << 16) / mb;
            if (!neg && qm > 64'h7FFFFFFF) begin
                q = 32'h7FFFFFFF; ov = 1'b1;
            end else if (neg && qm > 64'h80000000) begin
                q = 32'h80000000; ov = 1'b1;
            end else begin
                q = neg ? 32'(-qm) : 32'(qm);
            end
        end
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic dz, output logic ov, output int lat);
        @(negedge clk);
        in1 = a; in2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        q = Quotient_o; dz = div_by_zero; ov = overflow_o;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, div_by_zero, overflow_o} !== 4'b0 || Quotient_o !== 32'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b q=%h dz=%b ov=%b, required all zero",
                     busy, done, Quotient_o, div_by_zero, overflow_o);
        end
        @(negedge clk) rst = 1'b0;
        $display("reset: checked outputs after reset");
    endtask

    task automatic test_directed();
        logic [31:0] va[8] = '{32'h00060000, 32'hFFFF0000, 32'h00010000, 32'hFFFF0000,
                               32'h40000000, 32'h80000000, 32'h00000000, 32'h7FFFFFFF};
        logic [31:0] vb[8] = '{32'h00020000, 32'h00040000, 32'h00030000, 32'h00030000,
                               32'h00004000, 32'h00010000, 32'hFFFD0000, 32'hFFFFFFFF};
        logic [31:0] q, eq;
        logic dz, ov, edz, eov;
        int lat;
        for (int i = 0; i < 8; i++) begin
            run_op(va[i], vb[i], q, dz, ov, lat);
            model(va[i], vb[i], eq, edz, eov);
            checks++;
            if (q !== eq || dz !== edz || ov !== eov || lat != LAT_NORM || busy !== 1'b0) begin
                errors++;
                $display("FAIL directed %h/%h: q=%h dz=%b ov=%b lat=%0d busy=%b, required q=%h dz=%b ov=%b lat=%0d busy=0",
                         va[i], vb[i], q, dz, ov, lat, busy, eq, edz, eov, LAT_NORM);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || Quotient_o !== eq) begin
                errors++;
                $display("FAIL done_pulse %h/%h: done=%b q=%h, required done=0 q=%h",
                         va[i], vb[i], done, Quotient_o, eq);
            end
            $display("directed: %h / %h -> %h dz=%b ov=%b lat=%0d", va[i], vb[i], q, dz, ov, lat);
        end
    endtask

    task automatic test_div_by_zero();
        logic [31:0] va[3] = '{32'h00050000, 32'hFFFB0000, 32'h00000000};
        logic [31:0] q, eq;
        logic dz, ov, edz, eov;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], 32'd0, q, dz, ov, lat);
            model(va[i], 32'd0, eq, edz, eov);
            checks++;
            if (q !== eq || dz !== edz || ov !== eov || lat != 1) begin
                errors++;
                $display("FAIL div_by_zero %h/0: q=%h dz=%b ov=%b lat=%0d, required q=%h dz=%b ov=%b lat=1",
                         va[i], q, dz, ov, lat, eq, edz, eov);
            end
            $display("div_by_zero: %h / 0 -> %h dz=%b lat=%0d", va[i], q, dz, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, eq;
        logic dz, ov, edz, eov;
        int lat;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 0) a = $signed(a) >>> $urandom_range(16, 0);
            if (i % 2 == 0) b = $signed(b) >>> $urandom_range(24, 4);
            if (b == 32'd0) b = 32'h00010000;
            run_op(a, b, q, dz, ov, lat);
            model(a, b, eq, edz, eov);
            checks++;
            if (q !== eq || dz !== edz || ov !== eov || lat != LAT_NORM) begin
                errors++;
                $display("FAIL random %h/%h: q=%h dz=%b ov=%b lat=%0d, required q=%h dz=%b ov=%b lat=%0d",
                         a, b, q, dz, ov, lat, eq, edz, eov, LAT_NORM);
            end
            $display("random: %h / %h -> %h ov=%b", a, b, q, ov);
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] eq;
        logic edz, eov;
        int dones = 0;
        int first = -1;
        model(32'h00070000, 32'h00020000, eq, edz, eov);
        @(negedge clk);
        in1 = 32'h00070000; in2 = 32'h00020000; start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (10) @(negedge clk);
        in1 = 32'h00010000; in2 = 32'd0; start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 12; c < 120; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                dones++;
                if (first < 0) first = c;
                checks++;
                if (Quotient_o !== eq || div_by_zero !== 1'b0) begin
                    errors++;
                    $display("FAIL start_ignored_result: q=%h dz=%b, required q=%h dz=0",
                             Quotient_o, div_by_zero, eq);
                end
            end
        end
        checks++;
        if (dones != 1 || first != LAT_NORM) begin
            errors++;
            $display("FAIL start_ignored: dones=%0d first_done_edge=%0d, required 1 done at %0d",
                     dones, first, LAT_NORM);
        end
        $display("start_ignored: dones=%0d at edge %0d", dones, first);
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        @(negedge clk);
        in1 = 32'h00090000; in2 = 32'h00020000; start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || Quotient_o !== 32'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: busy=%b q=%h done=%b, required busy=0 q=0 done=0",
                     busy, Quotient_o, done);
        end
        @(negedge clk) rst = 1'b0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_abort_no_done: dones=%0d, required 0", dones);
        end
        $display("reset_abort: busy=%b q=%h dones_after=%0d", busy, Quotient_o, dones);
    endtask

    task automatic test_back_to_back();
        logic [31:0] q, eq1, eq2;
        logic dz, ov, edz, eov;
        int lat;
        model(32'h000A0000, 32'h00040000, eq1, edz, eov);
        model(32'hFFF40000, 32'h00050000, eq2, edz, eov);
        run_op(32'h000A0000, 32'h00040000, q, dz, ov, lat);
        checks++;
        if (q !== eq1 || lat != LAT_NORM || busy !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_first: q=%h lat=%0d busy=%b, required q=%h lat=%0d busy=0",
                     q, lat, busy, eq1, LAT_NORM);
        end
        in1 = 32'hFFF40000; in2 = 32'h00050000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_accept: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        lat = 0;
        while (done !== 1'b1 && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (Quotient_o !== eq2 || lat != LAT_NORM || overflow_o !== edz) begin
            errors++;
            $display("FAIL back_to_back_second: q=%h ov=%b lat=%0d, required q=%h ov=0 lat=%0d",
                     Quotient_o, overflow_o, lat, eq2, LAT_NORM);
        end
        $display("back_to_back: %h then %h", q, Quotient_o);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_by_zero();
        test_random();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
